// File: rtl/weight_loader.sv
// Weight stream loader: parses header+payload words from the config port and
// drives the shared weight-memory write bus with one write per accepted payload word.
module weight_loader #(
    parameter int unsigned cfgWidth     = 32,
    parameter int unsigned dataWidth    = 16,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned numLayers    = 4,
    parameter int unsigned maxWeights   = 784
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    input  logic [cfgWidth-1:0]     cfg_data,
    output logic                    cfg_ready,
    output logic [7:0]              w_layer,
    output logic [7:0]              w_neuron,
    output logic                    w_wen,
    output logic [addressWidth-1:0] w_wadd,
    output logic [dataWidth-1:0]    w_win,
    output logic                    load_done,
    output logic                    load_err
);

    localparam int unsigned hdr_w = 32;
    localparam int unsigned idx_w = 16;

    typedef struct packed {
        logic [7:0]       layer;
        logic [7:0]       neuron;
        logic [idx_w-1:0] count;
    } hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DROP,
        DONE
    } state_t;

    state_t                  state, state_nx;
    logic [idx_w-1:0]        idx, idx_nx;
    logic [idx_w-1:0]        cnt, cnt_nx;
    logic                    ready_nx;
    logic [7:0]              layer_nx, neuron_nx;
    logic                    wen_nx;
    logic [addressWidth-1:0] wadd_nx;
    logic [dataWidth-1:0]    win_nx;
    logic                    done_nx;
    logic                    err_nx;

    hdr_t hdr;
    logic accept;
    logic illegal;
    logic last_word;

    assign hdr       = hdr_t'(cfg_data[hdr_w-1:0]);
    assign accept    = cfg_valid & cfg_ready;
    assign illegal   = (32'(hdr.layer) >= numLayers) || (32'(hdr.count) > maxWeights);
    assign last_word = (idx == (cnt - idx_w'(1)));

    // Next-state and next-output decode
    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cnt_nx    = cnt;
        layer_nx  = w_layer;
        neuron_nx = w_neuron;
        wen_nx    = 1'b0;
        wadd_nx   = w_wadd;
        win_nx    = w_win;
        err_nx    = load_err;

        case (state)
            IDLE: begin
                if (accept) begin
                    layer_nx  = hdr.layer;
                    neuron_nx = hdr.neuron;
                    cnt_nx    = hdr.count;
                    idx_nx    = '0;
                    err_nx    = 1'b0;
                    if (hdr.count == '0) begin
                        state_nx = DONE;
                    end else if (illegal) begin
                        err_nx   = 1'b1;
                        state_nx = DROP;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    wen_nx  = 1'b1;
                    wadd_nx = idx[addressWidth-1:0];
                    win_nx  = cfg_data[dataWidth-1:0];
                    idx_nx  = idx + idx_w'(1);
                    if (last_word) begin
                        state_nx = DONE;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    idx_nx = idx + idx_w'(1);
                    if (last_word) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // ready drops only for the single completion cycle
        ready_nx = (state_nx != DONE);
        done_nx  = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            cfg_ready <= 1'b1;
            w_layer   <= '0;
            w_neuron  <= '0;
            w_wen     <= 1'b0;
            w_wadd    <= '0;
            w_win     <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            cfg_ready <= ready_nx;
            w_layer   <= layer_nx;
            w_neuron  <= neuron_nx;
            w_wen     <= wen_nx;
            w_wadd    <= wadd_nx;
            w_win     <= win_nx;
            load_done <= done_nx;
            load_err  <= err_nx;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed and random blocks checked every cycle
// against a transaction-level model of the loader.
module tb_weight_loader;

    localparam int NUM_LAYERS = 4;
    localparam int MAX_W      = 784;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic [7:0]  w_layer;
    logic [7:0]  w_neuron;
    logic        w_wen;
    logic [9:0]  w_wadd;
    logic [15:0] w_win;
    logic        load_done;
    logic        load_err;

    weight_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .w_layer   (w_layer),
        .w_neuron  (w_neuron),
        .w_wen     (w_wen),
        .w_wadd    (w_wadd),
        .w_win     (w_win),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;

    typedef struct {
        logic [9:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: expected bus state after each edge
    bit          e_ready;
    bit          e_wen;
    bit          e_done;
    bit          e_err;
    logic [7:0]  e_layer;
    logic [7:0]  e_neuron;
    logic [9:0]  e_wadd;
    logic [15:0] e_win;
    int          remaining;
    int          widx;
    bit          in_block;
    bit          dropping;
    bit          done_cycle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_ready = 1'b1; e_wen = 1'b0; e_done = 1'b0; e_err = 1'b0;
            e_layer = '0; e_neuron = '0; e_wadd = '0; e_win = '0;
            remaining = 0; widx = 0; in_block = 1'b0; dropping = 1'b0; done_cycle = 1'b0;
        end else begin
            e_wen  = 1'b0;
            e_done = 1'b0;
            if (done_cycle) begin
                done_cycle = 1'b0;
                e_ready    = 1'b1;
            end else if (cfg_valid) begin
                if (!in_block) begin
                    e_layer   = cfg_data[31:24];
                    e_neuron  = cfg_data[23:16];
                    remaining = int'(cfg_data[15:0]);
                    widx      = 0;
                    e_err     = 1'b0;
                    if (remaining == 0) begin
                        done_cycle = 1'b1; e_done = 1'b1; e_ready = 1'b0;
                    end else begin
                        in_block = 1'b1;
                        dropping = (int'(e_layer) >= NUM_LAYERS) || (remaining > MAX_W);
                        e_err    = dropping;
                    end
                end else begin
                    if (!dropping) begin
                        e_wen  = 1'b1;
                        e_wadd = 10'(widx % 1024);
                        e_win  = cfg_data[15:0];
                    end
                    widx++;
                    remaining--;
                    if (remaining == 0) begin
                        in_block = 1'b0; done_cycle = 1'b1; e_done = 1'b1; e_ready = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
        chk("w_wen",     32'(w_wen),     32'(e_wen));
        chk("load_done", 32'(load_done), 32'(e_done));
        chk("load_err",  32'(load_err),  32'(e_err));
        chk("w_layer",   32'(w_layer),   32'(e_layer));
        chk("w_neuron",  32'(w_neuron),  32'(e_neuron));
        chk("w_wadd",    32'(w_wadd),    32'(e_wadd));
        chk("w_win",     32'(w_win),     32'(e_win));
        if (w_wen === 1'b1) wlog.push_back('{a: w_wadd, d: w_win});
        if (load_done === 1'b1) n_done++;
    end

    task automatic put(input logic [31:0] w, input int gap);
        int guard;
        bit took;
        for (int g = 0; g < gap; g++) begin
            cfg_valid = 1'b0;
            cfg_data  = $urandom;
            @(negedge clk);
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        guard = 0;
        forever begin
            took = e_ready;
            @(negedge clk);
            if (took) break;
            guard++;
            if (guard > 8) begin
                n_cmp++;
                n_err++;
                $display("FAIL put_timeout: word 0x%0h not accepted within 8 cycles", w);
                break;
            end
        end
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
    endtask

    task automatic blk(input int l, input int n, input int c, input int gapmax);
        put({8'(l), 8'(n), 16'(c)}, $urandom_range(gapmax, 0));
        for (int i = 0; i < c; i++)
            put({16'($urandom), 16'($urandom)}, $urandom_range(gapmax, 0));
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    logic [15:0] exp1[3];
    int d0;

    initial begin
        exp1[0] = 16'h0011; exp1[1] = 16'h0022; exp1[2] = 16'h0033;
        rst_n = 1'b1; cfg_valid = 1'b0; cfg_data = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_wen",   32'(w_wen), 0);
        chk("rst_wadd",  32'(w_wadd), 0);
        chk("rst_win",   32'(w_win), 0);
        chk("rst_layer", 32'(w_layer), 0);
        chk("rst_done",  32'(load_done), 0);
        chk("rst_err",   32'(load_err), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back block
        wlog.delete(); d0 = n_done;
        put(32'h0105_0003, 0);
        put(32'hABCD_0011, 0);
        put(32'h1234_0022, 0);
        put(32'hFFFF_0033, 0);
        settle();
        chk("t1_nwr", 32'(wlog.size()), 3);
        if (wlog.size() == 3)
            for (int i = 0; i < 3; i++) begin
                chk("t1_wadd", 32'(wlog[i].a), 32'(i));
                chk("t1_win",  32'(wlog[i].d), 32'(exp1[i]));
            end
        chk("t1_layer",  32'(w_layer), 1);
        chk("t1_neuron", 32'(w_neuron), 5);
        chk("t1_ndone",  32'(n_done - d0), 1);

        // valid toggling every other cycle
        wlog.delete();
        put(32'h0105_0003, 1);
        for (int i = 0; i < 3; i++) put({16'h5A5A, exp1[i]}, 1);
        settle();
        chk("t2_nwr", 32'(wlog.size()), 3);
        if (wlog.size() == 3)
            for (int i = 0; i < 3; i++) chk("t2_wadd", 32'(wlog[i].a), 32'(i));

        // zero-count header followed immediately by another header
        wlog.delete(); d0 = n_done;
        put(32'h0207_0000, 0);
        put(32'h0203_0001, 0);
        put(32'h0000_0ABC, 0);
        settle();
        chk("t3_nwr", 32'(wlog.size()), 1);
        if (wlog.size() == 1) chk("t3_win", 32'(wlog[0].d), 32'h0ABC);
        chk("t3_ndone", 32'(n_done - d0), 2);

        // illegal layer is dropped; next legal header clears the error
        wlog.delete();
        put(32'h0400_0002, 0);
        chk("t4_err", 32'(load_err), 1);
        put(32'h0000_1111, 0);
        put(32'h0000_2222, 0);
        settle();
        chk("t4_nwr", 32'(wlog.size()), 0);
        put(32'h0001_0002, 0);
        chk("t4_clr", 32'(load_err), 0);
        put(32'h0000_3333, 0);
        put(32'h0000_4444, 0);
        settle();

        // max-size block and one over
        wlog.delete();
        blk(3, 9, MAX_W, 0);
        settle();
        chk("t5_nwr", 32'(wlog.size()), 784);
        if (wlog.size() > 0) chk("t5_last", 32'(wlog[wlog.size()-1].a), 783);
        put(32'h0000_0311, 0);
        chk("t5_err", 32'(load_err), 1);
        for (int i = 0; i < 785; i++) put($urandom, 0);
        settle();
        chk("t5_drop", 32'(wlog.size()), 784);

        // reset in the middle of a block
        wlog.delete();
        put(32'h0102_0005, 0);
        put(32'h0000_00A1, 0);
        put(32'h0000_00A2, 0);
        cfg_valid = 1'b1; cfg_data = 32'h0000_00A3;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_wen",   32'(w_wen), 0);
        chk("t6_wadd",  32'(w_wadd), 0);
        chk("t6_win",   32'(w_win), 0);
        chk("t6_layer", 32'(w_layer), 0);
        chk("t6_neur",  32'(w_neuron), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wlog.delete();
        put(32'h0304_0002, 0);
        put(32'h0000_0B01, 0);
        put(32'h0000_0B02, 0);
        settle();
        chk("t6_nwr", 32'(wlog.size()), 2);
        if (wlog.size() == 2) chk("t6_first", 32'(wlog[0].a), 0);

        // random blocks
        repeat (40) begin
            int l, n, c;
            l = $urandom_range(5, 0);
            n = $urandom_range(255, 0);
            c = ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(24, 1);
            blk(l, n, c, $urandom_range(2, 0));
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Stream-to-memory writer that fills the per-neuron weight memories of non-pretrained builds. It accepts a header-plus-payload word stream on a valid/ready configuration port and drives the shared write bus (layer/neuron select, write enable, write address, write data). Each neuron's weight memory decodes the bus by matching its own layer and neuron number. It sits between the host configuration interface and every weight memory in the network.

## Interface
Parameters:
- cfgWidth, 32, configuration word width; must be at least 32 and at least dataWidth.
- dataWidth, 16, weight word width; matches the weight memories.
- addressWidth, 10, weight memory address width.
- numLayers, 4, number of valid layer indices (0..numLayers-1).
- maxWeights, 784, largest legal payload count; must be at most 2^addressWidth.

Ports:
- clk, in, 1, single clock; all logic samples on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cfg_valid, in, 1, cfg_data holds a valid word.
- cfg_data, in, cfgWidth, header or payload word.
- cfg_ready, out, 1, loader accepts a word this cycle.
- w_layer, out, 8, target layer for the current write.
- w_neuron, out, 8, target neuron for the current write.
- w_wen, out, 1, write strobe to the weight memories.
- w_wadd, out, addressWidth, write address.
- w_win, out, dataWidth, write data.
- load_done, out, 1, one-cycle pulse when a block finishes.
- load_err, out, 1, sticky flag: last header was illegal.

## Operation
- A word transfers on a rising edge where cfg_valid and cfg_ready are both 1. cfg_data is ignored at all other times.
- Header word fields:
  - [31:24] layer
  - [23:16] neuron
  - [15:0] count
- Payload words follow the header. Each carries one weight in cfg_data[dataWidth-1:0]; upper bits are ignored.
- States and transitions:
  - IDLE (cfg_ready=1). On an accepted header:
    - latch layer, neuron and count; clear the index counter; clear load_err.
    - count==0: go to DONE.
    - layer>=numLayers or count>maxWeights: set load_err and go to DROP.
    - otherwise go to DATA.
  - DATA (cfg_ready=1). Each accepted word causes one write: w_wadd=index, w_win=data. The index then increments. After the word with index==count-1, go to DONE.
  - DROP (cfg_ready=1). Accept and discard exactly count words with no writes, then go to DONE.
  - DONE (cfg_ready=0). Stay one cycle with load_done=1, then go to IDLE.
- The index counter is 16 bits and counts 0..count-1. It never wraps inside a block. w_wadd is the low addressWidth bits of the index.
- w_layer and w_neuron hold the latched header values from header acceptance until the next header.
- No back-pressure is applied in IDLE, DATA or DROP; a cfg_valid gap simply stalls the block. Partial blocks persist until reset.

## Timing
- Reset values (asynchronous, while rst_n=0): state IDLE, index 0, cfg_ready=1 after release, and the following outputs at 0: w_wen, w_wadd, w_win, w_layer, w_neuron, load_done, load_err.
- Write latency: for a payload word accepted at edge k, w_wen=1 in the cycle following edge k with matching w_wadd and w_win. The memory captures it at edge k+1. w_wen is 0 in all other cycles, and w_wadd/w_win hold their last values.
- Back-to-back payload words produce back-to-back writes at one write per cycle.
- load_done rises at the edge that accepts the last payload word, or the header when count==0. It lasts exactly one cycle, during which cfg_ready=0. The next header can be accepted at the following edge.
- load_err updates at the header-acceptance edge and holds until the next accepted header.
- Reset asserted mid-block aborts immediately with no further writes. Words already written remain in memory.

## Test plan
- Header layer=1, neuron=5, count=3, then words 0x0011, 0x0022, 0x0033 back-to-back -> three consecutive w_wen cycles with w_wadd=0,1,2 and w_win=0x0011,0x0022,0x0033; w_layer=1, w_neuron=5; then load_done for 1 cycle with cfg_ready=0.
- Same block with cfg_valid toggling every other cycle -> writes occur only in cycles after accepted words; addresses stay contiguous; exactly 3 writes.
- Header count=0 -> no w_wen; load_done in the cycle after the header; the next header is accepted 2 edges after the first.
- Header layer=4 (numLayers=4), count=2, then 2 words -> load_err=1, no w_wen, load_done after the 2nd word. The next legal header clears load_err.
- Header count=784 with 784 words -> the last write has w_wadd=783. A header with count=785 -> load_err=1.
- rst_n pulled low after 2 of 5 payload words -> all outputs 0 immediately. After release, a new header is accepted in IDLE and its writes start at w_wadd=0.
